rs_scheduler: RTL and testbench
===============================

Name: rs_scheduler

Overview:
Reservation-station scheduler between dispatch and execute. Holds up to RS_ENTRIES micro-ops. Wakes operands on writeback tag broadcast, issues the oldest ready entry to execute, and frees an entry only when execute retires it over the execute_scheduler_if scheduler modport (retire_rs_entry / retire_rs_valid).

Parameters:
RS_ENTRIES, 8, number of entries (power of two, >=2); taken from CORE_PKG.
TAG_W, 6, physical register tag width.
PAYLOAD_W, 64, opaque uop payload width (opcode, imm, dest tag), passed through unchanged.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; empties all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one FREE entry
disp_payload  in  PAYLOAD_W  uop payload
disp_src1_tag  in  TAG_W  source 1 tag
disp_src1_rdy  in  1  source 1 already available
disp_src2_tag  in  TAG_W  source 2 tag
disp_src2_rdy  in  1  source 2 already available
wb_valid  in  1  writeback broadcast valid
wb_tag  in  TAG_W  broadcast tag
issue_valid  out  1  a READY entry is offered
issue_ready  in  1  execute accepts
issue_entry  out  clog2(RS_ENTRIES)  index of offered entry
issue_payload  out  PAYLOAD_W  payload of offered entry
retire_rs_valid  in  1  execute frees an entry (execute_scheduler_if.scheduler)
retire_rs_entry  in  clog2(RS_ENTRIES)  entry to free
occupancy  out  clog2(RS_ENTRIES+1)  count of non-FREE entries

Behaviour:
- Per-entry state register: FREE, WAITING, READY, ISSUED. Per-entry src1_rdy, src2_rdy, tags, payload, and an RS_ENTRIES x RS_ENTRIES age matrix (bit[i][j]=1: i older than j).
- Reset (async, rst_n low): all entries FREE, age matrix 0, issue_valid 0, occupancy 0, disp_ready 0 while rst_n low, 1 from the first clock after release.
- disp_ready, issue_valid, issue_entry, issue_payload, occupancy are combinational from registered state only. No same-cycle path from retire, wakeup or dispatch inputs.
- Dispatch fires on disp_valid & disp_ready. Writes into the lowest-index FREE entry. The new entry becomes older-than-none: its row is cleared and its column is set in all other valid rows.
- Dispatch state: READY if both srcs are ready after wakeup bypass, otherwise WAITING. Bypass means a src is also ready if wb_valid and wb_tag equals that src tag in the same cycle.
- Wakeup: each WAITING entry sets srcN_rdy when wb_valid and the tag matches. The entry becomes READY next cycle when both are set. A READY transition is not issuable in the cycle it is written; latency from wb_valid to issue_valid is 1 cycle.
- Select: issue_entry is the READY entry with no older READY entry. issue_valid=1 iff any entry is READY. payload and index stay stable while issue_valid & !issue_ready.
- Issue fires on issue_valid & issue_ready. The entry goes READY->ISSUED. Its operands stay held until retire.
- Retire: retire_rs_valid with an ISSUED entry makes it FREE next cycle and clears its age row/column. Retire of a non-ISSUED entry is ignored, no state change. A retired entry is not reusable by a dispatch in the same cycle; it is FREE for dispatch the next cycle.
- Simultaneous dispatch + retire + issue on different entries in the same cycle: all take effect. occupancy = old + dispatch_fire - retire_effective.
- Full: disp_ready=0 and disp_valid is ignored; the dispatch payload is not captured.
- flush has priority over all other inputs. Next cycle: all FREE, issue_valid=0, occupancy=0. Same-cycle dispatch/retire/wakeup are discarded.
- Reset asserted mid-operation immediately clears everything. No partial entries survive.

Test Plan:
- Reset, then dispatch 8 uops with both srcs ready -> occupancy 8, disp_ready=0. A 9th disp_valid is not captured. issue_entry order 0..7 with issue_ready held 1.
- Dispatch entry0 waiting on tag 5, entry1 waiting on tag 9. wb_tag=9 at cycle t -> issue_valid at t+1 with issue_entry=1. wb_tag=5 later -> entry0 issues.
- Dispatch src1_tag=3 not ready in the same cycle as wb_valid, wb_tag=3 -> entry READY, issue_valid next cycle.
- Age check: fill 0..3, retire entry 1, dispatch new into entry 1, make all ready -> issue order 0,2,3,1.
- Retire an entry in READY state -> ignored, occupancy unchanged. Retire an ISSUED entry while dispatch_valid on a full RS -> no capture that cycle, disp_ready=1 next cycle.
- flush with 5 entries (2 ISSUED) plus simultaneous dispatch -> next cycle occupancy 0, issue_valid 0. rst_n low mid-stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/rs_scheduler_if.sv
// Bundles shared by the reservation-station scheduler.
//
// rs_scheduler_if: dispatch, writeback broadcast and issue handshakes.
//   master: the pipeline side (dispatch stage, writeback bus, execute accept).
//   slave : the scheduler.
//   disp_*      dispatch request/ready, payload, source tags and readiness
//   wb_*        writeback tag broadcast
//   issue_*     offered entry index/payload, execute accept
//   occupancy   count of occupied entries
//
// execute_scheduler_if: execute tells the scheduler to free an entry.
//   execute  : drives retire_rs_valid / retire_rs_entry
//   scheduler: consumes them
interface rs_scheduler_if #(
    parameter int RS_ENTRIES = 8,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 64
);
    localparam int IDX_W = $clog2(RS_ENTRIES);
    localparam int OCC_W = $clog2(RS_ENTRIES + 1);

    logic                 disp_valid;
    logic                 disp_ready;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [TAG_W-1:0]     disp_src1_tag;
    logic                 disp_src1_rdy;
    logic [TAG_W-1:0]     disp_src2_tag;
    logic                 disp_src2_rdy;
    logic                 wb_valid;
    logic [TAG_W-1:0]     wb_tag;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [IDX_W-1:0]     issue_entry;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [OCC_W-1:0]     occupancy;

    modport master (
        output disp_valid, disp_payload, disp_src1_tag, disp_src1_rdy,
               disp_src2_tag, disp_src2_rdy, wb_valid, wb_tag, issue_ready,
        input  disp_ready, issue_valid, issue_entry, issue_payload, occupancy
    );

    modport slave (
        input  disp_valid, disp_payload, disp_src1_tag, disp_src1_rdy,
               disp_src2_tag, disp_src2_rdy, wb_valid, wb_tag, issue_ready,
        output disp_ready, issue_valid, issue_entry, issue_payload, occupancy
    );
endinterface

interface execute_scheduler_if #(
    parameter int RS_ENTRIES = 8
);
    localparam int IDX_W = $clog2(RS_ENTRIES);

    logic             retire_rs_valid;
    logic [IDX_W-1:0] retire_rs_entry;

    modport execute   (output retire_rs_valid, retire_rs_entry);
    modport scheduler (input  retire_rs_valid, retire_rs_entry);
endinterface

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler between dispatch and execute.
// Holds up to RS_ENTRIES uops, wakes their sources on writeback tag
// broadcast, offers the oldest READY entry to execute, and frees an entry
// only when execute retires it.
//
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   flush  empties all entries next cycle, overriding every other input
//   rs_if  dispatch / writeback / issue handshakes and occupancy (slave)
//   ex_if  retire from execute (scheduler modport)
//
// All outputs are decoded from registered state only.
module rs_scheduler #(
    parameter int RS_ENTRIES = 8,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    rs_scheduler_if.slave            rs_if,
    execute_scheduler_if.scheduler   ex_if
);
    localparam int IDX_W = $clog2(RS_ENTRIES);
    localparam int OCC_W = $clog2(RS_ENTRIES + 1);

    typedef enum logic [1:0] {ST_FREE, ST_WAITING, ST_READY, ST_ISSUED} rs_state_e;

    rs_state_e             state_q    [RS_ENTRIES];
    rs_state_e             state_d    [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] src1_rdy_q, src1_rdy_d;
    logic [RS_ENTRIES-1:0] src2_rdy_q, src2_rdy_d;
    logic [TAG_W-1:0]      src1_tag_q [RS_ENTRIES];
    logic [TAG_W-1:0]      src1_tag_d [RS_ENTRIES];
    logic [TAG_W-1:0]      src2_tag_q [RS_ENTRIES];
    logic [TAG_W-1:0]      src2_tag_d [RS_ENTRIES];
    logic [PAYLOAD_W-1:0]  payload_q  [RS_ENTRIES];
    logic [PAYLOAD_W-1:0]  payload_d  [RS_ENTRIES];
    // age_q[i][j] = 1 : entry i is older than entry j
    logic [RS_ENTRIES-1:0] age_q      [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] age_d      [RS_ENTRIES];
    // Holds disp_ready low until the first clock after reset release.
    logic                  init_done_q;

    logic [RS_ENTRIES-1:0] free_vec;
    logic [RS_ENTRIES-1:0] ready_vec;
    logic [RS_ENTRIES-1:0] oldest_vec;
    logic [RS_ENTRIES-1:0] older_col  [RS_ENTRIES];
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      issue_idx;
    logic [OCC_W-1:0]      occ_cnt;
    logic                  disp_ready_w;
    logic                  disp_fire;
    logic                  issue_fire;
    logic                  retire_fire;
    logic                  byp1, byp2;

    generate
        for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
            assign free_vec[gi]  = (state_q[gi] == ST_FREE);
            assign ready_vec[gi] = (state_q[gi] == ST_READY);
            // Column gi of the age matrix: which entries are older than gi.
            for (genvar gj = 0; gj < RS_ENTRIES; gj++) begin : g_col
                assign older_col[gi][gj] = age_q[gj][gi];
            end
            assign oldest_vec[gi] = ready_vec[gi] & ~|(ready_vec & older_col[gi]);
        end
    endgenerate

    // Lowest-index free entry, lowest-index oldest-ready entry (the age
    // matrix makes oldest_vec one-hot; the priority pick is only a guard).
    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        occ_cnt   = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i])   free_idx  = IDX_W'(i);
            if (oldest_vec[i]) issue_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            occ_cnt = occ_cnt + {{(OCC_W-1){1'b0}}, ~free_vec[i]};
        end
    end

    assign disp_ready_w        = init_done_q & (|free_vec);
    assign rs_if.disp_ready    = disp_ready_w;
    assign rs_if.issue_valid   = |ready_vec;
    assign rs_if.issue_entry   = issue_idx;
    assign rs_if.issue_payload = payload_q[issue_idx];
    assign rs_if.occupancy     = occ_cnt;

    assign disp_fire   = rs_if.disp_valid & disp_ready_w;
    assign issue_fire  = rs_if.issue_valid & rs_if.issue_ready;
    assign retire_fire = ex_if.retire_rs_valid &
                         (state_q[ex_if.retire_rs_entry] == ST_ISSUED);

    // A dispatching source also counts as ready if its tag is broadcast now.
    assign byp1 = rs_if.disp_src1_rdy | (rs_if.wb_valid & (rs_if.wb_tag == rs_if.disp_src1_tag));
    assign byp2 = rs_if.disp_src2_rdy | (rs_if.wb_valid & (rs_if.wb_tag == rs_if.disp_src2_tag));

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            state_d[i]    = state_q[i];
            src1_tag_d[i] = src1_tag_q[i];
            src2_tag_d[i] = src2_tag_q[i];
            payload_d[i]  = payload_q[i];
            age_d[i]      = age_q[i];
        end
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;

        if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                state_d[i] = ST_FREE;
                age_d[i]   = '0;
            end
            src1_rdy_d = '0;
            src2_rdy_d = '0;
        end else begin
            // Wakeup: READY is registered here, so it is offered next cycle.
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (state_q[i] == ST_WAITING && rs_if.wb_valid) begin
                    if (rs_if.wb_tag == src1_tag_q[i]) src1_rdy_d[i] = 1'b1;
                    if (rs_if.wb_tag == src2_tag_q[i]) src2_rdy_d[i] = 1'b1;
                    if (src1_rdy_d[i] && src2_rdy_d[i]) state_d[i] = ST_READY;
                end
            end

            if (issue_fire) state_d[issue_idx] = ST_ISSUED;

            if (retire_fire) begin
                state_d[ex_if.retire_rs_entry]    = ST_FREE;
                src1_rdy_d[ex_if.retire_rs_entry] = 1'b0;
                src2_rdy_d[ex_if.retire_rs_entry] = 1'b0;
                age_d[ex_if.retire_rs_entry]      = '0;
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    age_d[j][ex_if.retire_rs_entry] = 1'b0;
                end
            end

            // free_idx comes from registered state, so an entry retired this
            // cycle is never the dispatch target.
            if (disp_fire) begin
                state_d[free_idx]    = (byp1 && byp2) ? ST_READY : ST_WAITING;
                src1_rdy_d[free_idx] = byp1;
                src2_rdy_d[free_idx] = byp2;
                src1_tag_d[free_idx] = rs_if.disp_src1_tag;
                src2_tag_d[free_idx] = rs_if.disp_src2_tag;
                payload_d[free_idx]  = rs_if.disp_payload;
                age_d[free_idx]      = '0;
                // Every entry still occupied after this cycle is older.
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (j != int'(free_idx) && state_d[j] != ST_FREE) begin
                        age_d[j][free_idx] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            src1_rdy_q  <= '0;
            src2_rdy_q  <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                state_q[i]    <= ST_FREE;
                src1_tag_q[i] <= '0;
                src2_tag_q[i] <= '0;
                payload_q[i]  <= '0;
                age_q[i]      <= '0;
            end
        end else begin
            init_done_q <= 1'b1;
            src1_rdy_q  <= src1_rdy_d;
            src2_rdy_q  <= src2_rdy_d;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                state_q[i]    <= state_d[i];
                src1_tag_q[i] <= src1_tag_d[i];
                src2_tag_q[i] <= src2_tag_d[i];
                payload_q[i]  <= payload_d[i];
                age_q[i]      <= age_d[i];
            end
        end
    end
endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: fill/full, wakeup latency, dispatch
// bypass, age ordering after reuse, retire filtering, flush and async reset.
module tb_rs_scheduler;
    localparam int N  = 8;
    localparam int TW = 6;
    localparam int PW = 64;

    logic clk;
    logic rst_n;
    logic flush;

    int check_cnt = 0;
    int err_cnt   = 0;

    rs_scheduler_if #(.RS_ENTRIES(N), .TAG_W(TW), .PAYLOAD_W(PW)) rs_if ();
    execute_scheduler_if #(.RS_ENTRIES(N)) ex_if ();

    rs_scheduler #(.RS_ENTRIES(N), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .rs_if (rs_if),
        .ex_if (ex_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        rs_if.disp_valid    = 1'b0;
        rs_if.disp_payload  = '0;
        rs_if.disp_src1_tag = '0;
        rs_if.disp_src1_rdy = 1'b0;
        rs_if.disp_src2_tag = '0;
        rs_if.disp_src2_rdy = 1'b0;
        rs_if.wb_valid      = 1'b0;
        rs_if.wb_tag        = '0;
        ex_if.retire_rs_valid = 1'b0;
        ex_if.retire_rs_entry = '0;
        flush = 1'b0;
    endtask

    task automatic set_disp(input logic [63:0] p, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2);
        rs_if.disp_valid    = 1'b1;
        rs_if.disp_payload  = p;
        rs_if.disp_src1_tag = t1;
        rs_if.disp_src1_rdy = r1;
        rs_if.disp_src2_tag = t2;
        rs_if.disp_src2_rdy = r2;
    endtask

    task automatic disp(input logic [63:0] p, input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2);
        set_disp(p, t1, r1, t2, r2);
        $display("disp payload=%0h t1=%0d r1=%0b t2=%0d r2=%0b", p, t1, r1, t2, r2);
        tick();
        clr_inputs();
    endtask

    task automatic retire(input int e);
        ex_if.retire_rs_valid = 1'b1;
        ex_if.retire_rs_entry = 3'(e);
        $display("retire entry=%0d", e);
        tick();
        clr_inputs();
    endtask

    task automatic wb(input logic [5:0] t);
        rs_if.wb_valid = 1'b1;
        rs_if.wb_tag   = t;
        $display("wb tag=%0d", t);
        tick();
        clr_inputs();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        $display("flush");
        tick();
        clr_inputs();
    endtask

    int exp_order [4] = '{0, 2, 3, 1};
    logic [63:0] exp_pay [4] = '{64'hA0, 64'hA2, 64'hA3, 64'hA4};

    initial begin
        rst_n = 1'b0;
        rs_if.issue_ready = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_disp_ready", 64'(rs_if.disp_ready), 64'd0);
        check("rst_issue_valid", 64'(rs_if.issue_valid), 64'd0);
        check("rst_occupancy", 64'(rs_if.occupancy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_disp_ready", 64'(rs_if.disp_ready), 64'd1);

        // Fill all eight with ready uops, execute not accepting.
        for (int i = 0; i < N; i++) begin
            disp(64'h100 + 64'(i), 6'd1, 1'b1, 6'd2, 1'b1);
            check("fill_occ", 64'(rs_if.occupancy), 64'(i + 1));
        end
        check("full_disp_ready", 64'(rs_if.disp_ready), 64'd0);
        disp(64'h999, 6'd1, 1'b1, 6'd2, 1'b1);
        check("full_ignore_occ", 64'(rs_if.occupancy), 64'd8);

        // Drain in order 0..7 with issue_ready held high.
        rs_if.issue_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("fill_issue_valid", 64'(rs_if.issue_valid), 64'd1);
            check("fill_issue_entry", 64'(rs_if.issue_entry), 64'(i));
            check("fill_issue_payload", rs_if.issue_payload, 64'h100 + 64'(i));
            $display("issue entry=%0d payload=%0h", rs_if.issue_entry, rs_if.issue_payload);
            tick();
        end
        rs_if.issue_ready = 1'b0;
        check("all_issued_valid", 64'(rs_if.issue_valid), 64'd0);
        check("all_issued_occ", 64'(rs_if.occupancy), 64'd8);

        // Retire an ISSUED entry while dispatching into the full RS.
        set_disp(64'h77, 6'd1, 1'b1, 6'd2, 1'b1);
        retire(3);
        check("retire_full_occ", 64'(rs_if.occupancy), 64'd7);
        check("retire_full_disp_ready", 64'(rs_if.disp_ready), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (i != 3) retire(i);
        end
        check("drained_occ", 64'(rs_if.occupancy), 64'd0);

        // Wakeup: entry0 waits on tag 5, entry1 on tag 9.
        disp(64'hB0, 6'd5, 1'b0, 6'd1, 1'b1);
        disp(64'hB1, 6'd9, 1'b0, 6'd1, 1'b1);
        check("wait_issue_valid", 64'(rs_if.issue_valid), 64'd0);
        rs_if.wb_valid = 1'b1;
        rs_if.wb_tag   = 6'd9;
        #1;
        check("wb_same_cycle_valid", 64'(rs_if.issue_valid), 64'd0);
        tick();
        clr_inputs();
        check("wb9_issue_valid", 64'(rs_if.issue_valid), 64'd1);
        check("wb9_issue_entry", 64'(rs_if.issue_entry), 64'd1);
        rs_if.issue_ready = 1'b1;
        tick();
        rs_if.issue_ready = 1'b0;
        check("after_issue1_valid", 64'(rs_if.issue_valid), 64'd0);
        wb(6'd5);
        check("wb5_issue_entry", 64'(rs_if.issue_entry), 64'd0);
        check("wb5_issue_payload", rs_if.issue_payload, 64'hB0);
        rs_if.issue_ready = 1'b1;
        tick();
        rs_if.issue_ready = 1'b0;
        retire(0);
        retire(1);
        check("wake_drained_occ", 64'(rs_if.occupancy), 64'd0);

        // Bypass: src1 tag 3 broadcast in the dispatch cycle.
        rs_if.wb_valid = 1'b1;
        rs_if.wb_tag   = 6'd3;
        disp(64'hC0, 6'd3, 1'b0, 6'd4, 1'b1);
        check("bypass_issue_valid", 64'(rs_if.issue_valid), 64'd1);
        check("bypass_issue_entry", 64'(rs_if.issue_entry), 64'd0);

        // Retire of a READY entry is ignored.
        retire(0);
        check("retire_ready_occ", 64'(rs_if.occupancy), 64'd1);
        check("retire_ready_valid", 64'(rs_if.issue_valid), 64'd1);
        do_flush();

        // Age: fill 0..3, entry1 issues and retires, new uop reuses slot 1.
        disp(64'hA0, 6'd10, 1'b0, 6'd10, 1'b0);
        disp(64'hA1, 6'd1, 1'b1, 6'd2, 1'b1);
        disp(64'hA2, 6'd10, 1'b0, 6'd1, 1'b1);
        disp(64'hA3, 6'd10, 1'b0, 6'd1, 1'b1);
        check("age_first_entry", 64'(rs_if.issue_entry), 64'd1);
        rs_if.issue_ready = 1'b1;
        tick();
        rs_if.issue_ready = 1'b0;
        retire(1);
        check("age_retire_occ", 64'(rs_if.occupancy), 64'd3);
        disp(64'hA4, 6'd10, 1'b0, 6'd1, 1'b1);
        check("age_reuse_occ", 64'(rs_if.occupancy), 64'd4);
        wb(6'd10);
        rs_if.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("age_issue_valid", 64'(rs_if.issue_valid), 64'd1);
            check("age_issue_entry", 64'(rs_if.issue_entry), 64'(exp_order[k]));
            check("age_issue_payload", rs_if.issue_payload, exp_pay[k]);
            $display("issue entry=%0d payload=%0h", rs_if.issue_entry, rs_if.issue_payload);
            tick();
        end
        rs_if.issue_ready = 1'b0;
        do_flush();
        check("flush1_occ", 64'(rs_if.occupancy), 64'd0);

        // Flush with 5 entries (2 issued) and a dispatch in the same cycle.
        for (int i = 0; i < 5; i++) disp(64'hD0 + 64'(i), 6'd1, 1'b1, 6'd2, 1'b1);
        rs_if.issue_ready = 1'b1;
        tick();
        tick();
        rs_if.issue_ready = 1'b0;
        check("pre_flush_occ", 64'(rs_if.occupancy), 64'd5);
        check("pre_flush_entry", 64'(rs_if.issue_entry), 64'd2);
        flush = 1'b1;
        disp(64'hEE, 6'd1, 1'b1, 6'd2, 1'b1);
        check("flush_occ", 64'(rs_if.occupancy), 64'd0);
        check("flush_issue_valid", 64'(rs_if.issue_valid), 64'd0);
        check("flush_disp_ready", 64'(rs_if.disp_ready), 64'd1);

        // Asynchronous reset mid-stream.
        disp(64'hF0, 6'd1, 1'b1, 6'd2, 1'b1);
        disp(64'hF1, 6'd1, 1'b1, 6'd2, 1'b1);
        check("pre_rst_occ", 64'(rs_if.occupancy), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_occ", 64'(rs_if.occupancy), 64'd0);
        check("async_rst_issue_valid", 64'(rs_if.issue_valid), 64'd0);
        check("async_rst_disp_ready", 64'(rs_if.disp_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst2_disp_ready", 64'(rs_if.disp_ready), 64'd1);
        check("post_rst2_occ", 64'(rs_if.occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule
